// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider
// Multi-cycle unsigned divider. It performs one restoring subtract-and-shift
// step per clock and exchanges operands and results over valid/ready
// handshakes. A zero divisor bypasses the iterations and returns an
// all-ones quotient, with the dividend as the remainder.
module seq_restoring_divider #(
    parameter int DATA_WD = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [DATA_WD-1:0] i_dividend,
    input  logic [DATA_WD-1:0] i_divisor,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [DATA_WD-1:0] o_quotient,
    output logic [DATA_WD-1:0] o_remainder,
    output logic               o_div_by_zero
);

    localparam int CNT_WD = (DATA_WD > 2) ? $clog2(DATA_WD) : 1;
    localparam logic [CNT_WD-1:0] LAST_ITER = CNT_WD'(DATA_WD - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_WD-1:0] q_q, q_d;
    // After the restore decision, the stored partial remainder is always
    // below the divisor. Its top bit is therefore always zero, so only the
    // low DATA_WD bits are kept. The working value is rebuilt at
    // DATA_WD+1 bits on every iteration.
    logic [DATA_WD-1:0] rem_q, rem_d;
    logic [DATA_WD-1:0] div_q, div_d;
    logic [CNT_WD-1:0]  cnt_q, cnt_d;
    logic [DATA_WD-1:0] quot_q, quot_d;
    logic [DATA_WD-1:0] rem_out_q, rem_out_d;
    logic               dbz_q, dbz_d;

    logic [DATA_WD:0]   rem_shift;
    logic [DATA_WD:0]   trial;
    logic               q_bit;
    logic [DATA_WD-1:0] rem_next;
    logic [DATA_WD-1:0] q_next;

    // Next-state logic: handshake decoding plus one restoring iteration.
    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        rem_d     = rem_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        quot_d    = quot_q;
        rem_out_d = rem_out_q;
        dbz_d     = dbz_q;

        rem_shift = {rem_q, q_q[DATA_WD-1]};
        trial     = rem_shift - {1'b0, div_q};
        q_bit     = ~trial[DATA_WD];
        rem_next  = q_bit ? trial[DATA_WD-1:0] : rem_shift[DATA_WD-1:0];
        q_next    = {q_q[DATA_WD-2:0], q_bit};

        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    if (i_divisor != '0) begin
                        state_d = S_CALC;
                        q_d     = i_dividend;
                        div_d   = i_divisor;
                        rem_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d   = S_DONE;
                        quot_d    = '1;
                        rem_out_d = i_dividend;
                        dbz_d     = 1'b1;
                    end
                end
            end
            S_CALC: begin
                q_d   = q_next;
                rem_d = rem_next;
                cnt_d = cnt_q + CNT_WD'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d   = S_DONE;
                    quot_d    = q_next;
                    rem_out_d = rem_next;
                    dbz_d     = 1'b0;
                end
            end
            S_DONE: begin
                if (i_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset discards any in-flight result.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            q_q       <= '0;
            rem_q     <= '0;
            div_q     <= '0;
            cnt_q     <= '0;
            quot_q    <= '0;
            rem_out_q <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            rem_q     <= rem_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            quot_q    <= quot_d;
            rem_out_q <= rem_out_d;
            dbz_q     <= dbz_d;
        end
    end

    assign o_ready       = (state_q == S_IDLE);
    assign o_valid       = (state_q == S_DONE);
    assign o_quotient    = quot_q;
    assign o_remainder   = rem_out_q;
    assign o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider
// Scoreboard bench for the 4-bit sequential restoring divider. It covers
// directed cases, an exhaustive sweep with stalls, a reset during a
// calculation, and operands that change while the divider is busy.
module tb_seq_restoring_divider;

    localparam int W = 4;

    logic         i_clk;
    logic         i_rst;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_dividend;
    logic [W-1:0] i_divisor;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_quotient;
    logic [W-1:0] o_remainder;
    logic         o_div_by_zero;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
    } res_t;

    res_t exp_q[$];
    int   n_checks;
    int   n_errors;
    int   n_results;
    int   hs_cnt;
    bit   junk_on;

    seq_restoring_divider #(.DATA_WD(W)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_dividend   (i_dividend),
        .i_divisor    (i_divisor),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_quotient   (o_quotient),
        .o_remainder  (o_remainder),
        .o_div_by_zero(o_div_by_zero)
    );

    // Free-running clock
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Count every result handshake the DUT actually completes
    always @(posedge i_clk) begin
        if (!i_rst && o_valid && i_ready) begin
            hs_cnt <= hs_cnt + 1;
        end
    end

    // Reference model: quotient, remainder, flag and expected latency
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        res_t r;
        if (b == '0) begin
            r.q   = '1;
            r.r   = a;
            r.dbz = 1'b1;
            r.lat = 1;
        end else begin
            r.q   = a / b;
            r.r   = a % b;
            r.dbz = 1'b0;
            r.lat = W + 1;
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic stepClock;
        @(posedge i_clk);
        #1;
    endtask

    // While the divider is busy, scramble the request inputs so that any
    // use of them outside IDLE is visible
    task automatic scrambleInputs;
        if (junk_on) begin
            i_valid    = 1'b1;
            i_dividend = W'($urandom_range(0, 15));
            i_divisor  = W'($urandom_range(0, 15));
        end
    endtask

    // Present one request, wait for acceptance, push the expected result
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input bit junk);
        int guard;
        i_dividend = a;
        i_divisor  = b;
        i_valid    = 1'b1;
        guard      = 0;
        while (!o_ready && guard < 50) begin
            stepClock();
            guard++;
        end
        if (!o_ready) begin
            checkOutput("accept_timeout", 32'(o_ready), 32'd1);
        end
        stepClock();
        exp_q.push_back(model(a, b));
        junk_on = junk;
        if (junk) begin
            scrambleInputs();
        end else begin
            i_valid = 1'b0;
        end
    endtask

    // Wait for the result, check latency and values, stall, then hand it off
    task automatic collectResult(input int stalls);
        res_t e;
        int   lat;
        lat     = 0;
        i_ready = (stalls == 0);
        while (!o_valid && lat < 40) begin
            checkOutput("ready_busy", 32'(o_ready), 32'd0);
            stepClock();
            scrambleInputs();
            lat++;
        end
        if (!o_valid || exp_q.size() == 0) begin
            checkOutput("result_timeout", 32'(o_valid), 32'(exp_q.size() != 0));
            i_valid = 1'b0;
            junk_on = 1'b0;
            return;
        end
        e = exp_q.pop_front();
        n_results++;
        checkOutput("latency", 32'(lat + 1), 32'(e.lat));
        checkOutput("quotient", 32'(o_quotient), 32'(e.q));
        checkOutput("remainder", 32'(o_remainder), 32'(e.r));
        checkOutput("div_by_zero", 32'(o_div_by_zero), 32'(e.dbz));
        checkOutput("ready_in_done", 32'(o_ready), 32'd0);
        for (int s = 0; s < stalls; s++) begin
            stepClock();
            scrambleInputs();
            checkOutput("hold_valid", 32'(o_valid), 32'd1);
            checkOutput("hold_ready", 32'(o_ready), 32'd0);
            checkOutput("hold_quotient", 32'(o_quotient), 32'(e.q));
            checkOutput("hold_remainder", 32'(o_remainder), 32'(e.r));
            checkOutput("hold_dbz", 32'(o_div_by_zero), 32'(e.dbz));
        end
        i_ready = 1'b1;
        stepClock();
        i_valid = 1'b0;
        i_ready = 1'b0;
        junk_on = 1'b0;
        checkOutput("valid_drop", 32'(o_valid), 32'd0);
        checkOutput("ready_back", 32'(o_ready), 32'd1);
        checkOutput("post_quotient", 32'(o_quotient), 32'(e.q));
    endtask

    // Main test sequence
    initial begin
        int dir_a[6];
        int dir_b[6];
        n_checks   = 0;
        n_errors   = 0;
        n_results  = 0;
        hs_cnt     = 0;
        junk_on    = 1'b0;
        i_rst      = 1'b1;
        i_valid    = 1'b0;
        i_ready    = 1'b0;
        i_dividend = '0;
        i_divisor  = '0;
        stepClock();
        stepClock();
        i_rst = 1'b0;
        checkOutput("rst_ready", 32'(o_ready), 32'd1);
        checkOutput("rst_valid", 32'(o_valid), 32'd0);
        checkOutput("rst_quotient", 32'(o_quotient), 32'd0);
        checkOutput("rst_remainder", 32'(o_remainder), 32'd0);
        checkOutput("rst_dbz", 32'(o_div_by_zero), 32'd0);

        // Directed cases: 13/3, 7/0 and the boundary operands
        dir_a = '{13, 7, 15, 2, 15, 0};
        dir_b = '{3, 0, 1, 9, 15, 5};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(W'(dir_a[i]), W'(dir_b[i]), 1'b0);
            collectResult(0);
        end

        // Exhaustive sweep with random stalls and scrambled busy-time inputs
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                applyStimulus(W'(a), W'(b), 1'($urandom_range(0, 1)));
                collectResult(int'($urandom_range(0, 3)));
            end
        end

        // Reset during iteration 2 of 14/3 discards the result
        applyStimulus(4'd14, 4'd3, 1'b0);
        stepClock();
        stepClock();
        i_rst = 1'b1;
        stepClock();
        i_rst = 1'b0;
        exp_q.delete();
        checkOutput("midrst_ready", 32'(o_ready), 32'd1);
        checkOutput("midrst_valid", 32'(o_valid), 32'd0);
        checkOutput("midrst_quotient", 32'(o_quotient), 32'd0);
        checkOutput("midrst_remainder", 32'(o_remainder), 32'd0);
        checkOutput("midrst_dbz", 32'(o_div_by_zero), 32'd0);
        i_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            stepClock();
            checkOutput("no_stale_valid", 32'(o_valid), 32'd0);
        end
        i_ready = 1'b0;
        applyStimulus(4'd9, 4'd4, 1'b0);
        collectResult(0);

        // One handshake per accepted request and an empty scoreboard
        stepClock();
        checkOutput("handshake_count", 32'(hs_cnt), 32'(n_results));
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_restoring_divider.md
# seq_restoring_divider

Multi-cycle unsigned integer divider: accepts a dividend/divisor pair over a valid/ready handshake and returns quotient and remainder after a fixed number of iterations, one restoring subtract-and-shift per clock. It is the inverse-arithmetic companion to the arithmetic datapath in `combinational/prog_add_sub`. It is used wherever a division result is needed without a full combinational array.

## Interface
- DATA_WD, 4, operand width in bits; legal values are 2 or greater.
- i_clk  input  1  clock; all state updates occur on the rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_valid  input  1  operand pair on i_dividend/i_divisor is valid.
- o_ready  output  1  divider can accept an operand pair.
- i_dividend  input  DATA_WD  unsigned dividend.
- i_divisor  input  DATA_WD  unsigned divisor.
- o_valid  output  1  result outputs are valid.
- i_ready  input  1  consumer accepts the result.
- o_quotient  output  DATA_WD  unsigned quotient.
- o_remainder  output  DATA_WD  unsigned remainder.
- o_div_by_zero  output  1  result came from a zero divisor.

## Operation
- The FSM has three states:
  - IDLE: o_ready=1 and o_valid=0.
  - CALC: o_ready=0 and o_valid=0.
  - DONE: o_ready=0 and o_valid=1.
- IDLE→CALC: on an edge with i_valid&o_ready and i_divisor≠0.
  - Latch the dividend into the quotient shift register and the divisor into the divisor register.
  - Clear the partial remainder, which is DATA_WD+1 bits wide.
  - Set the iteration counter to 0.
- IDLE→DONE: on an edge with i_valid&o_ready and i_divisor==0.
  - Load o_quotient = all ones, o_remainder = i_dividend, o_div_by_zero = 1.
- One CALC iteration per cycle:
  - Shift {rem, q} left by 1, so rem takes the quotient-register MSB.
  - Compute trial = rem − {1'b0, divisor} at DATA_WD+1 bits.
  - If the trial MSB is 0: rem = trial and the new q LSB = 1.
  - Otherwise: rem is unchanged and the new q LSB = 0.
- CALC→DONE: on the edge completing iteration DATA_WD−1 (counter == DATA_WD−1).
  - Drive the final q to o_quotient and rem[DATA_WD-1:0] to o_remainder.
  - Set o_div_by_zero = 0.
- DONE→IDLE: on an edge with i_ready=1.
- Output hold: o_quotient, o_remainder and o_div_by_zero are registered. They hold stable from entry into DONE until the next result load.
- Back-to-back transfers: a new request cannot be accepted in the same cycle as the result handshake. At most one operation is in flight.
- Input changes: i_valid, i_dividend and i_divisor are ignored outside IDLE.
- Arithmetic invariant for every non-zero divisor: dividend == quotient×divisor + remainder, with remainder < divisor.
- Reset forces:
  - the state to IDLE, so o_ready=1 and o_valid=0;
  - o_quotient = 0, o_remainder = 0, o_div_by_zero = 0;
  - the counter and partial remainder to 0.
- Reset applies from any state, including mid-CALC and in DONE with a pending result. An in-flight result is discarded, and no o_valid pulse follows.
- Reset takes priority over a simultaneous handshake.

## Timing
- Latency, counted from an acceptance edge at cycle 0:
  - non-zero divisor: o_valid is high from cycle DATA_WD+1 (after DATA_WD CALC cycles);
  - zero divisor: o_valid is high from cycle 1.
- o_ready rises in the cycle after the result handshake edge.
- Minimum initiation interval is DATA_WD+2 cycles when i_ready is held high.
- o_valid stays high for as many cycles as i_ready is held low, with no limit.
- o_ready and o_valid are never high in the same cycle.
- All outputs derive from registers only, with no combinational path from any input.

## Test plan
- 13/3 with i_ready=1 (DATA_WD=4): o_valid goes high 5 cycles after acceptance with o_quotient=4, o_remainder=1, o_div_by_zero=0. o_ready returns 1 cycle later.
- 7/0: o_valid is high 1 cycle after acceptance with o_quotient=15, o_remainder=7, o_div_by_zero=1.
- Boundary operands:
  - 15/1 → 15 r 0;
  - 2/9 → 0 r 2;
  - 15/15 → 1 r 0;
  - 0/5 → 0 r 0.
- Exhaustive sweep of all 256 pairs at DATA_WD=4, with random i_ready stalls: quotient and remainder match the reference model on every pair. While i_ready=0, outputs are stable and o_valid holds. Exactly one result is produced per accepted request.
- Reset mid-operation:
  - Setup: accept 14/3 and assert i_rst in CALC iteration 2.
  - Next cycle: o_ready=1, o_valid=0, and all outputs are 0.
  - Then 9/4 → 2 r 1 with normal latency. No stale result appears.
- Requests outside IDLE: hold i_valid=1 with changing operands during CALC and DONE. Only the operands present at acceptance are used, and o_ready stays 0 until after the result handshake.
